piso_serializer: RTL and testbench
==================================

# piso_serializer

Parallel-in, serial-out converter: the transmit-side counterpart of the team's `shift_register` (serial-in, parallel-out). It accepts an N-bit word through a valid/ready handshake and emits it one bit per enabled clock, MSB first by default, with a per-bit valid strobe. A `shift_register` clocked on the same `ena` and fed from `data_out` reconstructs the original word.

## Interface
- `N`, default 4: word width in bits. Legal range is N ≥ 2.
- `clk`  in  1: single clock. All state updates on the rising edge.
- `rst`  in  1: asynchronous, active-low reset. Asserts immediately; release is synchronised externally.
- `ena`  in  1: shift enable. When low, the shift state holds (stall).
- `load_valid`  in  1: `d` holds a word to send.
- `load_ready`  out  1: block can accept a word this cycle.
- `d`  in  N: parallel word. Sampled only on a load handshake.
- `data_out`  out  1: current serial bit.
- `data_valid`  out  1: `data_out` is a live bit of the current word.
- `done`  out  1: high while the last bit of a word is on `data_out`.

## Operation
- State machine has two states.
  - **IDLE**: no word in flight.
  - **SHIFT**: a word is being emitted.
- Internal state:
  - N-bit shift register `sreg`.
  - Bit counter `cnt`, width $clog2(N), counting 0..N-1.
- Load handshake: a word is accepted on a rising edge where `load_valid && load_ready`. On acceptance, `sreg <= d`, `cnt <= 0`, and the state becomes SHIFT.
- `ena` does not gate a load.
- `load_ready` (combinational) = (state == IDLE) || (state == SHIFT && cnt == N-1 && ena).
- This allows back-to-back words with no gap bit.
- SHIFT outputs:
  - `data_out = sreg[N-1]` (or `sreg[0]`, see Configuration).
  - `data_valid = 1`.
  - `done = (cnt == N-1)`.
- SHIFT with `ena` = 1 and no load:
  - If cnt < N-1: `sreg` shifts toward the output end, a zero fills the vacated end, and `cnt` increments.
  - If cnt == N-1: state becomes IDLE.
- SHIFT with `ena` = 0: `sreg`, `cnt` and the state all hold. `data_out`, `data_valid` and `done` stay stable.
- IDLE outputs: `data_out` = 0, `data_valid` = 0, `done` = 0.
- Reset values:
  - State IDLE, `sreg` = 0, `cnt` = 0.
  - `data_out` = 0, `data_valid` = 0, `done` = 0, `load_ready` = 1.
- Reset mid-word: the word is discarded. Nothing resumes after reset is released.
- `load_valid` while busy (not ready) is ignored. The upstream must hold it asserted.

## Timing
- Latency from the load edge to the first bit is 1 cycle. The MSB appears on `data_out` immediately after the accepting edge.
- A word occupies exactly N enabled cycles. With `ena` held high, that is N clocks.
- `done` is high for the entire final bit cycle, including any stall cycles during that bit.
- Back-to-back transfer: a load on the final-bit edge puts the new word's first bit on `data_out` on the next cycle. `data_valid` stays high throughout.
- Simultaneous final bit with `ena` = 0 and `load_valid` = 1: `load_ready` = 0, so there is no load and the last bit holds.
- Outputs `data_out`, `data_valid` and `done` are registered/state-decoded and glitch-free. `load_ready` is combinational from state and `ena`.

## Configuration
- Macro `PISO_LSB_FIRST_EN`.
- Undefined (default): the block emits MSB first. `data_out = sreg[N-1]` and `sreg` shifts left with a zero fill. This matches `shift_register` shifting in at bit 0.
- Defined: the block emits LSB first. `data_out = sreg[0]` and `sreg` shifts right with a zero fill.
- Handshake, counter and timing are identical in both builds.

## Test plan
- Reset: hold `rst` = 0 for 2 cycles with `load_valid` = 1.
  - Expect `data_valid` = 0, `data_out` = 0, `done` = 0, `load_ready` = 1 throughout.
  - Expect no load.
- Single word: N=4, `d` = 4'b1010, `ena` = 1, one-cycle load.
  - Expect `data_out` = 1,0,1,0 on the next 4 cycles.
  - Expect `done` high on the 4th cycle only, then `data_valid` = 0.
  - Expect a downstream `shift_register` to hold q = 4'b1010.
- Stall: same word, with `ena` = 0 for 3 cycles after the second bit.
  - Expect `data_out` to hold 0 and `cnt` to be frozen.
  - Expect the sequence to finish as 1,0,1,0 over 7 cycles.
- Back-to-back: load 4'b1100 and then 4'b0011 with `load_valid` held high.
  - Expect `load_ready` = 1 on the final-bit cycle.
  - Expect an 8-bit stream 1,1,0,0,0,0,1,1 with `data_valid` never dropping.
- Mid-word reset: assert `rst` = 0 asynchronously after bit 2 of 4'b1010.
  - Expect `data_valid` and `data_out` to go to 0 immediately, without waiting for a clock edge.
  - After release, expect IDLE with `load_ready` = 1.
- `PISO_LSB_FIRST_EN` build: `d` = 4'b1000.
  - Expect `data_out` = 0,0,0,1, with `done` on the last bit.

Source files
------------

// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in, serial-out converter with a valid/ready load
// handshake and a per-bit valid strobe. One bit is emitted per enabled clock.
// Build option: define PISO_LSB_FIRST_EN to emit LSB first (default MSB first).
module piso_serializer #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic         load_valid,
  output logic         load_ready,
  input  logic [N-1:0] d,
  output logic         data_out,
  output logic         data_valid,
  output logic         done
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  sreg_q, sreg_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          load_s;
  logic          last_s;

  assign last_s = (cnt_q == LAST);
  assign load_s = load_valid && load_ready;

  // State register; reset discards any word in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: a load always wins, otherwise leave SHIFT after the last enabled bit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (load_s) begin
          state_d = S_SHIFT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (load_s) begin
          state_d = S_SHIFT;
        end else if (ena && last_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_SHIFT;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Shift register and bit counter storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sreg_q <= {N{1'b0}};
      cnt_q  <= {CW{1'b0}};
    end else begin
      sreg_q <= sreg_d;
      cnt_q  <= cnt_d;
    end
  end

  // Datapath next state: load, shift with zero fill, or clear when the word ends.
  always_comb begin
    sreg_d = sreg_q;
    cnt_d  = cnt_q;
    if (load_s) begin
      sreg_d = d;
      cnt_d  = {CW{1'b0}};
    end else if ((state_q == S_SHIFT) && ena) begin
      if (!last_s) begin
`ifdef PISO_LSB_FIRST_EN
        sreg_d = {1'b0, sreg_q[N-1:1]};
`else
        sreg_d = {sreg_q[N-2:0], 1'b0};
`endif
        cnt_d  = cnt_q + CW'(1);
      end else begin
        // Word finished with no follow-on load: park cleared so IDLE shows zeros.
        sreg_d = {N{1'b0}};
        cnt_d  = {CW{1'b0}};
      end
    end else begin
      sreg_d = sreg_q;
      cnt_d  = cnt_q;
    end
  end

  // Output decode from registered state; only load_ready also looks at ena.
  always_comb begin
    load_ready = 1'b0;
    data_out   = 1'b0;
    data_valid = 1'b0;
    done       = 1'b0;
    case (state_q)
      S_IDLE: begin
        load_ready = 1'b1;
      end
      S_SHIFT: begin
        load_ready = last_s && ena;
`ifdef PISO_LSB_FIRST_EN
        data_out   = sreg_q[0];
`else
        data_out   = sreg_q[N-1];
`endif
        data_valid = 1'b1;
        done       = last_s;
      end
      default: begin
        load_ready = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer (N=4). Expected serial bits are
// queued when a load handshake is driven and popped as the DUT emits them.
module tb_piso_serializer;

  logic       clk;
  logic       rst;
  logic       ena;
  logic       load_valid;
  logic       load_ready;
  logic [3:0] d;
  logic       data_out;
  logic       data_valid;
  logic       done;

  int vectors = 0;
  int miscompares = 0;
  logic exp_q[$];

  piso_serializer #(.N(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .d          (d),
    .data_out   (data_out),
    .data_valid (data_valid),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Queue a word's bits in emission order.
  task automatic push_word(input logic [3:0] w);
`ifdef PISO_LSB_FIRST_EN
    for (int i = 0; i < 4; i++) exp_q.push_back(w[i]);
`else
    for (int i = 3; i >= 0; i--) exp_q.push_back(w[i]);
`endif
  endtask

  // Expected next bit; X when nothing is queued, which can never match.
  function automatic logic pop_exp();
    if (exp_q.size() == 0) return 1'bx;
    return exp_q.pop_front();
  endfunction

  // Word a downstream shift-in-at-bit-0 register would hold.
  function automatic logic [3:0] rx_word(input logic [3:0] w);
`ifdef PISO_LSB_FIRST_EN
    return {w[0], w[1], w[2], w[3]};
`else
    return w;
`endif
  endfunction

  task automatic test_reset();
    rst = 1'b0; ena = 1'b1; load_valid = 1'b1; d = 4'b1111;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      vectors++;
      if ({data_valid, data_out, done, load_ready} !== 4'b0001) begin
        miscompares++;
        $display("FAIL reset_outputs cyc%0d: got dv,do,done,rdy=%b%b%b%b want 0001",
                 k, data_valid, data_out, done, load_ready);
      end
    end
    rst = 1'b1; load_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (data_valid !== 1'b0 || load_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_no_load: got dv=%b rdy=%b want dv=0 rdy=1", data_valid, load_ready);
    end
  endtask

  task automatic test_single(input logic [3:0] w);
    logic e;
    logic [3:0] rx;
    rx = 4'b0000;
    ena = 1'b1; d = w; load_valid = 1'b1; #1;
    vectors++;
    if (load_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL single_ready_idle: got %b want 1", load_ready);
    end
    if (load_valid && load_ready) push_word(d);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      load_valid = 1'b0;
      e = pop_exp();
      vectors++;
      if (data_valid !== 1'b1 || data_out !== e) begin
        miscompares++;
        $display("FAIL single_bit w=%b k=%0d: got dv=%b do=%b want dv=1 do=%b",
                 w, k, data_valid, data_out, e);
      end
      vectors++;
      if (done !== (k == 3)) begin
        miscompares++;
        $display("FAIL single_done w=%b k=%0d: got %b want %b", w, k, done, (k == 3));
      end
      rx = {rx[2:0], data_out};
    end
    @(negedge clk);
    vectors++;
    if (data_valid !== 1'b0 || done !== 1'b0 || data_out !== 1'b0) begin
      miscompares++;
      $display("FAIL single_idle_after w=%b: got dv,done,do=%b%b%b want 000",
               w, data_valid, done, data_out);
    end
    vectors++;
    if (rx !== rx_word(w)) begin
      miscompares++;
      $display("FAIL single_downstream: got %b want %b", rx, rx_word(w));
    end
  endtask

  task automatic test_stall();
    logic e;
    int nvalid;
    nvalid = 0;
    e = 1'b0;
    ena = 1'b1; d = 4'b1010; load_valid = 1'b1; #1;
    if (load_valid && load_ready) push_word(d);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      load_valid = 1'b0;
      if (k < 2 || k > 4) e = pop_exp();
      if (data_valid === 1'b1) nvalid++;
      vectors++;
      if (data_out !== e || done !== (k == 6)) begin
        miscompares++;
        $display("FAIL stall_bit k=%0d: got do=%b done=%b want do=%b done=%b",
                 k, data_out, done, e, (k == 6));
      end
      if (k >= 2 && k <= 4) begin
        vectors++;
        if (load_ready !== 1'b0) begin
          miscompares++;
          $display("FAIL stall_ready k=%0d: got %b want 0", k, load_ready);
        end
      end
      if (k == 1) ena = 1'b0;
      if (k == 4) ena = 1'b1;
    end
    @(negedge clk);
    vectors++;
    if (nvalid != 7 || data_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_length: got %0d valid cycles, dv now %b; want 7, 0", nvalid, data_valid);
    end
  endtask

  task automatic test_final_stall();
    logic e;
    e = 1'b0;
    ena = 1'b1; d = 4'b1100; load_valid = 1'b1; #1;
    if (load_valid && load_ready) push_word(d);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      load_valid = 1'b0;
      e = pop_exp();
    end
    ena = 1'b0; load_valid = 1'b1; d = 4'b0011; #1;
    vectors++;
    if (load_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL final_stall_ready: got %b want 0", load_ready);
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b1 || data_valid !== 1'b1 || data_out !== e) begin
      miscompares++;
      $display("FAIL final_stall_hold: got done=%b dv=%b do=%b want 1 1 %b",
               done, data_valid, data_out, e);
    end
    load_valid = 1'b0; ena = 1'b1;
    @(negedge clk);
    vectors++;
    if (data_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL final_stall_noload: got dv=%b want 0", data_valid);
    end
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    logic e;
    ena = 1'b1; d = 4'b1100; load_valid = 1'b1; #1;
    if (load_valid && load_ready) push_word(d);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      e = pop_exp();
      vectors++;
      if (data_valid !== 1'b1 || data_out !== e) begin
        miscompares++;
        $display("FAIL b2b_bit k=%0d: got dv=%b do=%b want dv=1 do=%b", k, data_valid, data_out, e);
      end
      if (k == 3) begin
        vectors++;
        if (load_ready !== 1'b1 || done !== 1'b1) begin
          miscompares++;
          $display("FAIL b2b_ready_last: got rdy=%b done=%b want 1 1", load_ready, done);
        end
      end
      if (k == 0) d = 4'b0011;
      if (k == 4) load_valid = 1'b0;
      #1;
      if (load_valid && load_ready) push_word(d);
    end
    @(negedge clk);
    vectors++;
    if (data_valid !== 1'b0 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL b2b_end: got dv=%b leftover=%0d want dv=0 leftover=0", data_valid, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_mid_reset();
    logic e;
    ena = 1'b1; d = 4'b1010; load_valid = 1'b1; #1;
    if (load_valid && load_ready) push_word(d);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      load_valid = 1'b0;
      e = pop_exp();
      vectors++;
      if (data_valid !== 1'b1 || data_out !== e) begin
        miscompares++;
        $display("FAIL midrst_bit k=%0d: got dv=%b do=%b want 1 %b", k, data_valid, data_out, e);
      end
    end
    #2 rst = 1'b0;
    #1;
    vectors++;
    if ({data_valid, data_out, done, load_ready} !== 4'b0001) begin
      miscompares++;
      $display("FAIL midrst_async: got dv,do,done,rdy=%b%b%b%b want 0001",
               data_valid, data_out, done, load_ready);
    end
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    vectors++;
    if (data_valid !== 1'b0 || load_ready !== 1'b1 || data_out !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_idle: got dv=%b rdy=%b do=%b want 0 1 0", data_valid, load_ready, data_out);
    end
  endtask

  initial begin
    rst = 1'b0; ena = 1'b0; load_valid = 1'b0; d = 4'b0000;
    test_reset();
    test_single(4'b1010);
    test_single(4'b1000);
    test_stall();
    test_final_stall();
    test_back_to_back();
    test_mid_reset();
    test_single(4'b0110);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
